// File: rtl/mgmt_arb.sv
// mgmt_arb: round-robin arbiter sharing one management bus master port
// between N requesters. The winner's command is registered and held on the
// mgmt_* port until the slave acks or the timeout expires; a one-cycle ack
// (with read data) or err pulse then goes back to that requester, followed
// by a one-cycle GAP so mgmt_req is low for at least two cycles between
// transactions.
//
// Handshake: a requester raises rq_req[i] with stable fields and holds them
// until it sees rq_ack[i] or rq_err[i], then drops rq_req[i] in the following
// cycle. On the bus side mgmt_req is a level held high with constant fields
// until a single-cycle mgmt_ack (with mgmt_rxe/mgmt_rxd for reads) arrives.
module mgmt_arb #(
  parameter int N       = 2,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    rq_req,
  input  logic [32*N-1:0] rq_adr,
  input  logic [N-1:0]    rq_rwn,
  input  logic [2*N-1:0]  rq_wen,
  input  logic [32*N-1:0] rq_txd,
  output logic [N-1:0]    rq_ack,
  output logic [N-1:0]    rq_err,
  output logic            rq_rxe,
  output logic [31:0]     rq_rxd,
  output logic            mgmt_req,
  output logic [31:0]     mgmt_adr,
  input  logic            mgmt_ack,
  output logic            mgmt_rwn,
  output logic [1:0]      mgmt_wen,
  output logic [31:0]     mgmt_txd,
  input  logic            mgmt_rxe,
  input  logic [31:0]     mgmt_rxd
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt;
  logic [CW-1:0] cnt;
  logic [IW-1:0] pick;
  logic          pick_vld;

  // Round-robin search: first set request strictly after ptr, cyclically.
  // Scanning from the farthest candidate down lets the nearest one win last.
  always_comb begin
    logic [IW-1:0] jj;
    pick     = '0;
    pick_vld = 1'b0;
    jj       = '0;
    for (int k = N; k >= 1; k--) begin
      jj = IW'((int'(ptr) + k) % N);
      if (rq_req[jj]) begin
        pick     = jj;
        pick_vld = 1'b1;
      end
    end
  end

  // Arbitration FSM, bus command register, timeout counter and reply pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IW'(N - 1);
      gnt      <= '0;
      cnt      <= '0;
      mgmt_req <= 1'b0;
      mgmt_adr <= '0;
      mgmt_rwn <= 1'b1;
      mgmt_wen <= '0;
      mgmt_txd <= '0;
      rq_ack   <= '0;
      rq_err   <= '0;
      rq_rxe   <= 1'b0;
      rq_rxd   <= '0;
    end else begin
      // Reply outputs are single-cycle pulses; they clear unless set below.
      rq_ack <= '0;
      rq_err <= '0;
      rq_rxe <= 1'b0;
      rq_rxd <= '0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            mgmt_req <= 1'b1;
            mgmt_adr <= rq_adr[pick*32 +: 32];
            mgmt_rwn <= rq_rwn[pick];
            mgmt_wen <= rq_wen[pick*2 +: 2];
            mgmt_txd <= rq_txd[pick*32 +: 32];
            cnt      <= '0;
            ptr      <= pick;
            gnt      <= pick;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mgmt_ack) begin
            // Ack takes priority over a timeout expiring in the same cycle.
            mgmt_req    <= 1'b0;
            rq_ack[gnt] <= 1'b1;
            rq_rxe      <= mgmt_rxe;
            rq_rxd      <= mgmt_rxe ? mgmt_rxd : 32'd0;
            state       <= GAP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mgmt_req    <= 1'b0;
            rq_err[gnt] <= 1'b1;
            state       <= GAP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          // Requests are ignored here so the finishing requester, whose
          // rq_req is still high this cycle, cannot be re-granted.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_arb.sv
// Testbench for mgmt_arb (N = 2, TIMEOUT = 8): table-driven single
// transactions, then hand-written sequences for late ack after timeout,
// round-robin contention and reset in the middle of a transaction.
module tb_mgmt_arb;

  localparam int N  = 2;
  localparam int TO = 8;
  localparam int EW = 2 * N + 33;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    rq_req = '0;
  logic [32*N-1:0] rq_adr = '0;
  logic [N-1:0]    rq_rwn = '1;
  logic [2*N-1:0]  rq_wen = '0;
  logic [32*N-1:0] rq_txd = '0;
  logic [N-1:0]    rq_ack;
  logic [N-1:0]    rq_err;
  logic            rq_rxe;
  logic [31:0]     rq_rxd;
  logic            mgmt_req;
  logic [31:0]     mgmt_adr;
  logic            mgmt_ack = 1'b0;
  logic            mgmt_rwn;
  logic [1:0]      mgmt_wen;
  logic [31:0]     mgmt_txd;
  logic            mgmt_rxe = 1'b0;
  logic [31:0]     mgmt_rxd = '0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  mgmt_arb #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .rq_req(rq_req), .rq_adr(rq_adr), .rq_rwn(rq_rwn), .rq_wen(rq_wen),
    .rq_txd(rq_txd), .rq_ack(rq_ack), .rq_err(rq_err), .rq_rxe(rq_rxe),
    .rq_rxd(rq_rxd), .mgmt_req(mgmt_req), .mgmt_adr(mgmt_adr),
    .mgmt_ack(mgmt_ack), .mgmt_rwn(mgmt_rwn), .mgmt_wen(mgmt_wen),
    .mgmt_txd(mgmt_txd), .mgmt_rxe(mgmt_rxe), .mgmt_rxd(mgmt_rxd)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected completion word {rq_ack, rq_err, rq_rxe, rq_rxd}.
  function automatic logic [EW-1:0] mk_exp(input int r, input logic ok,
                                           input logic rxe, input logic [31:0] rxd);
    logic [N-1:0] one, a, e;
    one = '0;
    one[r] = 1'b1;
    a = ok ? one : {N{1'b0}};
    e = ok ? {N{1'b0}} : one;
    return {a, e, rxe, rxd};
  endfunction

  // Scoreboard: every reply pulse pops and compares the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (rq_ack != '0 || rq_err != '0 || rq_rxe || rq_rxd != '0)) begin
      if (exp_q.size() == 0) check("unexpected_reply", 64'({rq_ack, rq_err, rq_rxe, rq_rxd}), 64'd0);
      else check("reply", 64'({rq_ack, rq_err, rq_rxe, rq_rxd}), 64'(exp_q.pop_front()));
    end
  end

  // Driver tasks.
  task automatic drive_rq(input int r, input logic rwn, input logic [31:0] adr,
                          input logic [1:0] wen, input logic [31:0] txd);
    rq_req[r]          = 1'b1;
    rq_rwn[r]          = rwn;
    rq_adr[r*32 +: 32] = adr;
    rq_wen[r*2 +: 2]   = wen;
    rq_txd[r*32 +: 32] = txd;
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    while (!mgmt_req && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Slave model: called with mgmt_req high; acks on the (dly+1)-th high
  // cycle and returns in the cycle after mgmt_req drops (the pulse cycle).
  task automatic serve(input int dly, input logic rxe, input logic [31:0] rxd, output int n_hi);
    logic [66:0] first;
    int bad;
    bad  = 0;
    n_hi = 0;
    first = {mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd};
    while (mgmt_req && n_hi < 40) begin
      n_hi++;
      if ({mgmt_adr, mgmt_rwn, mgmt_wen, mgmt_txd} !== first) bad++;
      if (n_hi == dly + 1) begin
        mgmt_ack = 1'b1; mgmt_rxe = rxe; mgmt_rxd = rxd;
      end else begin
        mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
      end
      @(negedge clk);
    end
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    check("hold_stable", 64'(bad), 64'd0);
  endtask

  typedef struct {
    int          r;
    logic        rwn;
    logic [31:0] adr;
    logic [1:0]  wen;
    logic [31:0] txd;
    int          dly;
    logic        s_rxe;
    logic [31:0] s_rxd;
    int          exp_hi;
    logic        exp_ok;
    logic        exp_rxe;
    logic [31:0] exp_rxd;
  } vec_t;

  vec_t vec[7];

  task automatic run_txn(input vec_t v);
    int lat, n_hi;
    drive_rq(v.r, v.rwn, v.adr, v.wen, v.txd);
    exp_q.push_back(mk_exp(v.r, v.exp_ok, v.exp_rxe, v.exp_rxd));
    wait_grant(lat);
    check("grant_latency", 64'(lat), 64'd1);
    check("mgmt_adr", 64'(mgmt_adr), 64'(v.adr));
    check("mgmt_rwn_wen", 64'({mgmt_rwn, mgmt_wen}), 64'({v.rwn, v.wen}));
    check("mgmt_txd", 64'(mgmt_txd), 64'(v.txd));
    if (mgmt_req) begin
      serve(v.dly, v.s_rxe, v.s_rxd, n_hi);
      check("req_high_cycles", 64'(n_hi), 64'(v.exp_hi));
    end
    rq_req[v.r] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n_hi, cyc;
    logic [31:0] rnd_d;
    logic [31:0] rnd_a;
    int rnd_dly;

    rnd_d   = $urandom;
    rnd_a   = $urandom;
    rnd_dly = $urandom_range(0, 5);
    //            r  rwn adr           wen    txd           dly      s_rxe s_rxd          hi          ok    rxe   rxd
    vec[0] = '{0, 1'b1, 32'h10,       2'b00, 32'h0,       2,       1'b1, 32'hDEADBEEF, 3,          1'b1, 1'b1, 32'hDEADBEEF};
    vec[1] = '{1, 1'b0, 32'h20,       2'b01, 32'h1234,    2,       1'b0, 32'h0,        3,          1'b1, 1'b0, 32'h0};
    vec[2] = '{0, 1'b1, 32'h44,       2'b00, 32'h0,       0,       1'b1, 32'hA5A5A5A5, 1,          1'b1, 1'b1, 32'hA5A5A5A5};
    vec[3] = '{1, 1'b1, 32'h88,       2'b00, 32'h0,       TO-1,    1'b1, 32'h0BADF00D, TO,         1'b1, 1'b1, 32'h0BADF00D};
    vec[4] = '{0, 1'b0, 32'hC0,       2'b11, 32'hFFFF0000, 255,    1'b0, 32'h0,        TO,         1'b0, 1'b0, 32'h0};
    vec[5] = '{1, 1'b1, 32'hF0,       2'b00, 32'h0,       3,       1'b0, 32'hFFFFFFFF, 4,          1'b1, 1'b0, 32'h0};
    vec[6] = '{0, 1'b1, rnd_a,        2'b10, rnd_d,       rnd_dly, 1'b1, rnd_d,        rnd_dly+1,  1'b1, 1'b1, rnd_d};

    // Reset and reset-state checks.
    repeat (3) @(negedge clk);
    check("rst_mgmt_req", 64'(mgmt_req), 64'd0);
    check("rst_mgmt_rwn", 64'(mgmt_rwn), 64'd1);
    check("rst_mgmt_fields", 64'({mgmt_adr, mgmt_wen}), 64'd0);
    check("rst_mgmt_txd", 64'(mgmt_txd), 64'd0);
    check("rst_replies", 64'({rq_ack, rq_err, rq_rxe}), 64'd0);
    check("rst_rq_rxd", 64'(rq_rxd), 64'd0);
    rst = 1'b0;

    // Table-driven single transactions.
    for (int i = 0; i < 7; i++) run_txn(vec[i]);

    // Timeout followed by a late ack that must be ignored.
    drive_rq(0, 1'b1, 32'h55, 2'b00, 32'h0);
    exp_q.push_back(mk_exp(0, 1'b0, 1'b0, 32'h0));
    wait_grant(cyc);
    serve(255, 1'b0, 32'h0, n_hi);
    check("timeout_high_cycles", 64'(n_hi), 64'(TO));
    rq_req[0] = 1'b0;
    repeat (2) @(negedge clk);
    mgmt_ack = 1'b1; mgmt_rxe = 1'b1; mgmt_rxd = 32'h77777777;
    @(negedge clk);
    mgmt_ack = 1'b0; mgmt_rxe = 1'b0; mgmt_rxd = '0;
    check("late_ack_rq_ack", 64'(rq_ack), 64'd0);
    check("late_ack_rq_rxd", 64'(rq_rxd), 64'd0);
    check("late_ack_no_req", 64'(mgmt_req), 64'd0);
    repeat (2) @(negedge clk);

    // Contention from reset: both request continuously, order 0,1,0,1.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_rq(0, 1'b1, 32'h100, 2'b00, 32'h0);
    drive_rq(1, 1'b1, 32'h200, 2'b00, 32'h0);
    for (int t = 0; t < 4; t++) begin
      exp_q.push_back(mk_exp(t % 2, 1'b1, 1'b1, 32'hC0DE0000 + t));
      wait_grant(cyc);
      check("rr_order", 64'(mgmt_adr), (t % 2 == 1) ? 64'h200 : 64'h100);
      if (t > 0) check("idle_gap_ge2", 64'(cyc >= 2), 64'd1);
      serve(2, 1'b1, 32'hC0DE0000 + t, n_hi);
      check("rr_high_cycles", 64'(n_hi), 64'd3);
      if (t == 3) rq_req = '0;
    end
    repeat (2) @(negedge clk);

    // Reset during BUSY of a requester-0 transaction: no reply, pointer restored.
    drive_rq(0, 1'b1, 32'h300, 2'b00, 32'h0);
    @(negedge clk);
    check("mid_rst_granted", 64'(mgmt_req), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_req_low", 64'(mgmt_req), 64'd0);
    check("mid_rst_no_reply", 64'({rq_ack, rq_err}), 64'd0);
    rst = 1'b0;
    rq_req = '0;
    repeat (3) @(negedge clk);
    drive_rq(0, 1'b1, 32'h400, 2'b00, 32'h0);
    drive_rq(1, 1'b1, 32'h500, 2'b00, 32'h0);
    exp_q.push_back(mk_exp(0, 1'b1, 1'b1, 32'h11110000));
    wait_grant(cyc);
    check("post_rst_first_grant", 64'(mgmt_adr), 64'h400);
    serve(1, 1'b1, 32'h11110000, n_hi);
    rq_req[0] = 1'b0;
    exp_q.push_back(mk_exp(1, 1'b1, 1'b1, 32'h22220000));
    wait_grant(cyc);
    check("post_rst_second_grant", 64'(mgmt_adr), 64'h500);
    serve(1, 1'b1, 32'h22220000, n_hi);
    rq_req[1] = 1'b0;
    repeat (4) @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mgmt_arb.md
Name: mgmt_arb

Overview:
- Round-robin arbiter sharing one management bus master port between N requesters (e.g. core LSU system-register path and debug port).
- Drives the mgmt_* slave interface of the system-register block and the memory-controller config block.
- Registers the winner's command, holds it until the slave acks or a timeout expires, then returns read data or an error pulse to that requester.
- Guarantees the idle gap the slaves need between back-to-back transactions.

Parameters:
- N, 2, number of requesters (2..8).
- TIMEOUT, 8, cycles mgmt_req may stay high without mgmt_ack before the transaction is aborted (≥4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rq_req  in  N  per-requester request level; bit i = requester i
- rq_adr  in  32*N  address; requester i at [32i+31:32i]
- rq_rwn  in  N  1 = read, 0 = write
- rq_wen  in  2*N  halfword write enables; requester i at [2i+1:2i]
- rq_txd  in  32*N  write data
- rq_ack  out  N  one-cycle completion pulse to the granted requester
- rq_err  out  N  one-cycle timeout pulse to the granted requester
- rq_rxe  out  1  read-data valid; coincides with the rq_ack pulse
- rq_rxd  out  32  read data; 0 when rq_rxe = 0
- mgmt_req  out  1  bus request level
- mgmt_adr  out  32  address
- mgmt_ack  in  1  slave completion pulse
- mgmt_rwn  out  1  read/not-write
- mgmt_wen  out  2  write enables
- mgmt_txd  out  32  write data
- mgmt_rxe  in  1  slave read-data valid; accompanies mgmt_ack
- mgmt_rxd  in  32  slave read data

Behaviour:
- All outputs are registered.
- Reset values:
  - mgmt_req = 0, mgmt_adr/mgmt_wen/mgmt_txd = 0, mgmt_rwn = 1.
  - rq_ack = rq_err = 0, rq_rxe = 0, rq_rxd = 0.
  - State = IDLE, round-robin pointer = N-1, so requester 0 has first priority.
- Requester contract:
  - Hold rq_req[i] and all its fields stable from assertion until rq_ack[i] or rq_err[i] is seen.
  - Deassert rq_req[i] in the cycle after that pulse.
- States:
  - IDLE:
    - If any rq_req bit is set, grant the first set bit strictly after the pointer, searching cyclically.
    - On the grant: latch that requester's adr/rwn/wen/txd onto mgmt_*, set mgmt_req = 1, clear the timeout counter, set pointer = grant index, go BUSY.
    - If no rq_req bit is set, stay in IDLE.
  - BUSY:
    - mgmt_req is held high and mgmt_* fields are held constant. The counter increments each cycle.
    - If mgmt_ack = 1:
      - Next cycle: mgmt_req = 0, rq_ack[grant] = 1, rq_rxe = mgmt_rxe, rq_rxd = mgmt_rxe ? mgmt_rxd : 0.
      - Go GAP.
    - Else if counter = TIMEOUT-1:
      - Next cycle: mgmt_req = 0, rq_err[grant] = 1, rq_rxe = 0, rq_rxd = 0.
      - Go GAP.
    - If ack and timeout fall in the same cycle, ack wins.
  - GAP:
    - Lasts exactly one cycle; pulses are visible during it. Always go IDLE.
    - rq_req is ignored in GAP, so the finishing requester cannot be re-granted.
- Spacing:
  - mgmt_req stays low for at least 2 cycles between transactions (GAP + IDLE-evaluation cycle).
  - The slave's busy/issue pipeline therefore never double-issues.
- Latency (slave ack 2 cycles after it sees mgmt_req):
  - rq_req rises at cycle 0 → mgmt_req high at cycle 1 → mgmt_ack at cycle 3 → rq_ack at cycle 4.
  - Next grant is possible at the edge ending cycle 5 (mgmt_req high at cycle 6).
- Ignored inputs:
  - mgmt_ack or mgmt_rxe outside BUSY (e.g. a late ack after a timeout) is ignored.
  - rq_rxd is not updated in that case.
- Pulses:
  - rq_ack, rq_err and rq_rxe are single-cycle.
  - At most one bit of rq_ack | rq_err is set in any cycle.
- Counter: width $clog2(TIMEOUT)+1; it saturates and never wraps while in BUSY.
- Fairness: after requester i is served, every other pending requester is served before i again, so any requester waits at most N-1 transactions.
- Reset mid-transaction:
  - Return to IDLE with mgmt_req = 0 on the next edge.
  - No ack or err pulse is generated for the aborted transaction.
  - The pointer returns to N-1.
- A requester dropping rq_req while in BUSY is a protocol violation. The transaction still completes and its pulse is still issued.

Test Plan:
- Single read: rq_req[0] = 1, adr = 0x10; slave acks 2 cycles after mgmt_req with rxe = 1, rxd = 0xDEADBEEF → mgmt_req high cycles 1–3, rq_ack[0] and rq_rxe at cycle 4, rq_rxd = 0xDEADBEEF.
- Write path: rq_req[1] = 1, rwn = 0, wen = 2'b01, txd = 0x1234 → mgmt_wen = 01, mgmt_txd = 0x1234 held stable through BUSY; rq_ack[1] pulses with rq_rxe = 0 and rq_rxd = 0.
- Contention: both requesters assert continuously for 4 transactions from reset → grant order 0,1,0,1; mgmt_req low ≥2 cycles between each.
- Timeout: slave never acks, TIMEOUT = 8 → mgmt_req high exactly 8 cycles, then rq_err[0] pulses and rq_ack stays 0. A late ack 2 cycles later is ignored, with rq_ack = 0 and rq_rxd unchanged.
- Ack on last count: mgmt_ack arrives with counter = TIMEOUT-1 → rq_ack pulses and rq_err stays 0.
- Reset mid-BUSY: assert rst for 1 cycle at cycle 2 of a transaction → mgmt_req = 0 next cycle, no rq_ack/rq_err pulse, next grant goes to requester 0.
